// File: rtl/pe_dispatch_ctrl_pkg.sv
// Shared types for the PE dispatch scheduler: instruction/control layouts, FSM and fault codes.
// decode_op resolves one operand against the per-PE issued/written scoreboard.
package pe_sched_pkg;

    localparam logic [2:0] SEL_IMM = 3'd7;

    typedef struct packed {
        logic [3:0] op0;
        logic [3:0] op1;
        logic       use_imm0;
        logic       use_imm1;
        logic [1:0] alu_op;
    } instr_t;

    typedef struct packed {
        logic [2:0] sel0;
        logic [2:0] sel1;
        logic [1:0] alu_op;
    } pe_ctrl_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FAULT = 2'd3
    } sched_state_t;

    typedef enum logic [1:0] {
        FC_NONE  = 2'b00,
        FC_FWD   = 2'b01,
        FC_RANGE = 2'b10
    } fault_code_t;

    typedef struct packed {
        logic [2:0]  sel;
        logic [3:0]  imm;
        fault_code_t fc;
        logic        stall;
    } op_dec_t;

    function automatic op_dec_t decode_op(
        input logic [3:0] op,
        input logic       use_imm,
        input logic [7:0] issued,
        input logic [7:0] written,
        input int         num_pe
    );
        op_dec_t    d;
        logic [2:0] idx;
        idx     = op[2:0];
        d.sel   = 3'd0;
        d.imm   = 4'd0;
        d.fc    = FC_NONE;
        d.stall = 1'b0;
        if (use_imm) begin
            d.sel = SEL_IMM;
            d.imm = op;
        end else if (int'(idx) >= num_pe) begin
            d.fc = FC_RANGE;
        end else if (!issued[idx]) begin
            d.fc = FC_FWD;
        end else if (!written[idx]) begin
            d.stall = 1'b1;
        end else begin
            d.sel = idx;
        end
        return d;
    endfunction

endpackage

// File: rtl/pe_dispatch_ctrl_if.sv
// Instruction ingress and PE issue bundle; slave = scheduler, master = instruction source / PE array side.
interface pe_dispatch_ctrl_if #(
    parameter int NUM_PE = 4
);
    import pe_sched_pkg::*;

    logic              instr_valid;
    logic [11:0]       instr_data;
    logic              instr_ready;
    logic              clear;
    logic [NUM_PE-1:0] pe_en;
    pe_ctrl_t          pe_ctrl;
    logic [3:0]        pe_imm0;
    logic [3:0]        pe_imm1;
    logic [NUM_PE-1:0] pe_wb_en;
    logic              busy;
    logic              done;
    logic              fault;
    logic [1:0]        fault_code;

    modport master (
        output instr_valid, instr_data, clear,
        input  instr_ready, pe_en, pe_ctrl, pe_imm0, pe_imm1, pe_wb_en,
               busy, done, fault, fault_code
    );

    modport slave (
        input  instr_valid, instr_data, clear,
        output instr_ready, pe_en, pe_ctrl, pe_imm0, pe_imm1, pe_wb_en,
               busy, done, fault, fault_code
    );

endinterface

// File: rtl/pe_dispatch_ctrl_fifo.sv
// Generic power-of-2 FIFO; head visible combinationally, one-cycle write-to-read latency.
// Pushes while full and pops while empty are ignored; flush empties it in one cycle.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_wr      = i_push && !o_full;
    assign w_rd      = i_pop && !o_empty;
    assign o_pop_dat = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pe_dispatch_ctrl.sv
// In-order PE issue scheduler with operand scoreboard; push-to-issue >= 2 cycles, dependent stall 1 cycle.
// instr_ready is register-derived; optional PE_DISPATCH_PERF_EN adds stall_cycles/issue_count ports.
module pe_dispatch_ctrl
    import pe_sched_pkg::*;
#(
    parameter int NUM_PE     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int INSTR_W    = 12
) (
    input  logic               clock,
    input  logic               reset,
    pe_dispatch_ctrl_if.slave  bus
`ifdef PE_DISPATCH_PERF_EN
    ,
    output logic [15:0]        stall_cycles,
    output logic [7:0]         issue_count
`endif
);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_FAULT = FAULT;

    logic [1:0]         r_state;
    logic [2:0]         r_pe_idx;
    logic [NUM_PE-1:0]  r_issued;
    logic [NUM_PE-1:0]  r_written;
    logic [NUM_PE-1:0]  r_wb;
    logic               r_fault;
    logic [1:0]         r_fault_code;
    logic               r_done;

    logic [INSTR_W-1:0] w_head_raw;
    instr_t             w_head;
    op_dec_t            w_dec0;
    op_dec_t            w_dec1;
    pe_ctrl_t           w_ctrl;
    logic [1:0]         w_fc;
    logic [NUM_PE-1:0]  w_onehot;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_active;
    logic               w_fault_any;
    logic               w_blocked;
    logic               w_dispatch;
    logic               w_flush;

    assign w_head      = w_head_raw;
    assign w_dec0      = decode_op(w_head.op0, w_head.use_imm0, 8'(r_issued), 8'(r_written), NUM_PE);
    assign w_dec1      = decode_op(w_head.op1, w_head.use_imm1, 8'(r_issued), 8'(r_written), NUM_PE);
    assign w_active    = (r_state == ST_RUN) && !w_empty;
    assign w_fault_any = w_active && ((w_dec0.fc != FC_NONE) || (w_dec1.fc != FC_NONE));
    assign w_fc        = (w_dec0.fc != FC_NONE) ? w_dec0.fc : w_dec1.fc;
    assign w_blocked   = w_dec0.stall || w_dec1.stall;
    // clear outranks both a fault and a dispatch decoded in the same cycle
    assign w_dispatch  = w_active && !w_fault_any && !w_blocked && !bus.clear;
    assign w_flush     = bus.clear || w_fault_any;
    assign w_push      = bus.instr_valid && bus.instr_ready;
    assign w_onehot    = NUM_PE'(1) << r_pe_idx;
    assign w_ctrl      = {w_dec0.sel, w_dec1.sel, w_head.alu_op};

    assign bus.instr_ready = !w_full && (r_state != ST_FAULT);
    assign bus.pe_en       = w_dispatch ? w_onehot : '0;
    assign bus.pe_ctrl     = w_dispatch ? w_ctrl : '0;
    assign bus.pe_imm0     = w_dispatch ? w_dec0.imm : 4'd0;
    assign bus.pe_imm1     = w_dispatch ? w_dec1.imm : 4'd0;
    assign bus.pe_wb_en    = bus.clear ? '0 : r_wb;
    assign bus.busy        = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign bus.done        = r_done;
    assign bus.fault       = r_fault;
    assign bus.fault_code  = r_fault_code;

    instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk        (clock),
        .rst        (reset),
        .i_push     (w_push),
        .i_push_dat (bus.instr_data),
        .i_pop      (w_dispatch),
        .i_flush    (w_flush),
        .o_pop_dat  (w_head_raw),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_pe_idx     <= 3'd0;
            r_issued     <= '0;
            r_written    <= '0;
            r_wb         <= '0;
            r_fault      <= 1'b0;
            r_fault_code <= 2'b00;
            r_done       <= 1'b0;
        end else if (bus.clear) begin
            r_state      <= ST_IDLE;
            r_pe_idx     <= 3'd0;
            r_issued     <= '0;
            r_written    <= '0;
            r_wb         <= '0;
            r_fault      <= 1'b0;
            r_fault_code <= 2'b00;
            r_done       <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_wb      <= '0;
            r_written <= r_written | r_wb;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_fault_any) begin
                        r_state      <= ST_FAULT;
                        r_fault      <= 1'b1;
                        r_fault_code <= w_fc;
                    end else if (w_dispatch) begin
                        r_issued <= r_issued | w_onehot;
                        r_wb     <= w_onehot;
                        r_pe_idx <= r_pe_idx + 3'd1;
                        if (r_pe_idx == 3'(NUM_PE - 1)) r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // last PE writes back this cycle: program is complete
                    if (r_wb[NUM_PE-1]) begin
                        r_done    <= 1'b1;
                        r_issued  <= '0;
                        r_written <= '0;
                        r_pe_idx  <= 3'd0;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_FAULT: r_state <= ST_FAULT;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef PE_DISPATCH_PERF_EN
    logic        w_stall;
    logic [15:0] r_stall_cycles;
    logic [7:0]  r_issue_count;

    assign w_stall      = w_active && !w_fault_any && w_blocked && !bus.clear;
    assign stall_cycles = r_stall_cycles;
    assign issue_count  = r_issue_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= 16'd0;
            r_issue_count  <= 8'd0;
        end else if (bus.clear) begin
            r_stall_cycles <= 16'd0;
            r_issue_count  <= 8'd0;
        end else begin
            if (w_stall && (r_stall_cycles != 16'hFFFF)) r_stall_cycles <= r_stall_cycles + 16'd1;
            if (w_dispatch) r_issue_count <= r_issue_count + 8'd1;
        end
    end
`endif

endmodule

// File: doc/pe_dispatch_ctrl.md
Name: pe_dispatch_ctrl

Overview:
Instruction scheduler for the PE array. Buffers 12-bit instructions through a valid/ready FIFO and issues one per cycle to PEs in order (PE0, PE1, ...). Drives per-PE enable, the 8-bit control word, immediates and the result-register write enable. A per-PE scoreboard enforces operand dependencies: it stalls on in-flight results and faults on forward or out-of-range references.

Parameters:
NUM_PE, 4, number of PEs, legal range 2..7 (select code 7 is reserved for the immediate).
FIFO_DEPTH, 4, instruction FIFO entries, power of 2, at least 2.
INSTR_W, 12, instruction width, fixed.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
instr_valid  in  1  instruction offered
instr_data  in  12  instruction {op0[11:8], op1[7:4], use_imm0[3], use_imm1[2], alu_op[1:0]}
instr_ready  out  1  FIFO can accept
clear  in  1  synchronous abort/fault-clear pulse
pe_en  out  NUM_PE  one-hot issue strobe
pe_ctrl  out  8  {sel_op0[2:0], sel_op1[2:0], alu_op[1:0]}
pe_imm0  out  4  immediate operand 0
pe_imm1  out  4  immediate operand 1
pe_wb_en  out  NUM_PE  one-hot PE output-register enable
busy  out  1  state is RUN or DRAIN
done  out  1  one-cycle pulse when the program completes
fault  out  1  sticky fault flag
fault_code  out  2  00 none, 01 forward reference, 10 index >= NUM_PE

Behaviour:
- Reset values: all outputs 0, except instr_ready = 1. FIFO is empty, pe_idx = 0, scoreboard is cleared, state is IDLE.
- FIFO handshake:
  - A push occurs when instr_valid && instr_ready.
  - instr_ready = !full && state != FAULT. It is registered and never depends combinationally on a pop.
  - A push and a pop in the same cycle are both legal; occupancy is unchanged.
- Scoreboard: two bits per PE.
  - issued: set in the dispatch cycle.
  - written: set in the cycle pe_wb_en is asserted.
- States:
  - IDLE: go to RUN when the FIFO is non-empty.
  - RUN: each cycle with the FIFO non-empty, decode the head entry against the scoreboard.
  - DRAIN: wait for the last writeback, then pulse done for one cycle, clear the scoreboard, set pe_idx = 0 and return to IDLE.
  - FAULT: hold until clear.
- Operand decode, per operand:
  - use_imm = 1: sel = 7 and the immediate comes from op[3:0].
  - use_imm = 0: idx = op[2:0].
    - idx >= NUM_PE: fault code 10.
    - !issued[idx]: fault code 01.
    - issued && !written: stall (no pop, pe_en = 0, retry next cycle).
    - Otherwise sel = idx.
- Dispatch (cycle D, no stall or fault):
  - Pop the FIFO.
  - pe_en[pe_idx] = 1; pe_ctrl and pe_imm* are valid in the same cycle.
  - pe_wb_en[pe_idx] = 1 in cycle D+1.
  - Increment pe_idx.
  - Dispatch to the last PE (index NUM_PE-1) moves the state to DRAIN.
  - Latency from push to pe_en is at least 2 cycles. Back-to-back dependent instructions incur exactly a 1-cycle stall.
- Outputs while not dispatching: pe_ctrl and pe_imm* are 0 whenever pe_en is 0.
- Fault entry: if either operand faults, enter FAULT.
  - If both operands fault, op0's code wins.
  - fault = 1 and fault_code is latched; the faulting entry and the whole FIFO are flushed.
  - No pe_en in the faulting cycle.
- clear (any state): next state is IDLE.
  - FIFO flushed, scoreboard cleared, pe_idx = 0, fault and fault_code cleared.
  - An in-flight pe_wb_en due the next cycle is suppressed.
  - clear has priority over a fault or dispatch detected in the same cycle.
- reset mid-operation: immediate return to the reset values; no done pulse.

Optional Feature:
Macro: PE_DISPATCH_PERF_EN.
- Defined: adds output ports stall_cycles (16 bits) and issue_count (8 bits).
  - stall_cycles increments on each stall cycle and saturates at 0xFFFF.
  - issue_count increments per dispatch and wraps.
  - Both are zeroed by reset and by clear; both are held in FAULT.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Package pe_sched_pkg holds:
  - SEL_IMM = 3'd7.
  - Typedefs instr_t (packed struct of the instruction fields) and pe_ctrl_t (packed {sel0, sel1, alu_op}).
  - Enum sched_state_t {IDLE, RUN, DRAIN, FAULT}.
  - Enum fault_code_t.
- Sub-module: instr_fifo (parameterised depth/width; push, pop, flush, full, empty). Instantiate it once.

Test Plan:
- Independent program: 4 immediate-only instructions, pushed back-to-back (e.g. 0x35C with op0 = 3, op1 = 5, imm, alu 0).
  -> pe_en = 0001, 0010, 0100, 1000 on consecutive cycles; pe_wb_en follows each by 1 cycle.
  -> pe_ctrl = {7, 7, alu}; done pulses 1 cycle after the last pe_wb_en.
- Dependency stall: PE0 immediate, then PE1 using op0 = PE0 (instr 0x054).
  -> 1 stall cycle; PE1 issues with pe_ctrl[7:5] = 0.
- Forward reference: first instruction uses op0 = PE2, not immediate.
  -> fault = 1, fault_code = 01; no pe_en ever asserted; instr_ready = 0 until clear.
- Out-of-range operand: NUM_PE = 4, operand idx = 5.
  -> fault_code = 10; clear returns to IDLE; the next program runs from PE0.
- FIFO full: hold dispatch behind a stall, push 5 entries with FIFO_DEPTH = 4.
  -> instr_ready drops after 4 entries; the 5th entry is accepted only after a pop; order is preserved.
- Abort/reset: assert clear in the cycle after a dispatch.
  -> the expected pe_wb_en is suppressed and busy = 0.
  -> A mid-RUN reset yields all outputs at their reset values and no done pulse.
